// File: rtl/instruction_sequencer.sv
// Control FSM for a nibble-opcode machine: steers PC and fetch register, resolves
// two-byte jumps locally and hands single-byte ops to the datapath via valid/ready.
module instruction_sequencer #(
    parameter int         CNT_W   = 16,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       instr,
    input  logic [3:0]       operand,
    input  logic [7:0]       programByte,
    input  logic             carry,
    input  logic             zero,
    input  logic             exec_ready,
    input  logic             resume,
    output logic             enableFetch,
    output logic             enableCounter,
    output logic             load,
    output logic [11:0]      valueLoad,
    output logic             exec_valid,
    output logic [3:0]       exec_op,
    output logic [3:0]       exec_operand,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             taken;

    always_comb begin
        case (instr)
            4'h1:    taken = carry;
            4'h2:    taken = ~carry;
            4'h3:    taken = zero;
            4'h4:    taken = ~zero;
            4'h5:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        enableFetch   = 1'b0;
        enableCounter = 1'b0;
        load          = 1'b0;
        valueLoad     = 12'h000;
        exec_valid    = 1'b0;
        exec_op       = 4'h0;
        exec_operand  = 4'h0;
        halted        = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                enableFetch   = 1'b1;
                enableCounter = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                if (instr == HALT_OP) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else if (instr == 4'h0) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (instr <= 4'h5) begin
                    // PC already points at the address byte; skip it when not taken
                    retire        = 1'b1;
                    load          = taken;
                    enableCounter = ~taken;
                    valueLoad     = taken ? {operand, programByte} : 12'h000;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_valid   = 1'b1;
                exec_op      = instr;
                exec_operand = operand;
                if (exec_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench: models ROM, PC and fetch register around the sequencer and
// checks control outputs against hand-computed values.
module tb_instruction_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       instr, operand;
    logic [7:0]       programByte;
    logic             carry, zero, exec_ready, resume;
    logic             enableFetch, enableCounter, load;
    logic [11:0]      valueLoad;
    logic             exec_valid;
    logic [3:0]       exec_op, exec_operand;
    logic             halted;
    logic [CNT_W-1:0] retired;

    logic [7:0]  rom [0:4095];
    logic [11:0] pc;
    logic [7:0]  fr;
    int          n_tests = 0;
    int          n_fail  = 0;

    instruction_sequencer #(.CNT_W(CNT_W), .HALT_OP(4'hF)) dut (
        .clk(clk), .reset(reset), .instr(instr), .operand(operand),
        .programByte(programByte), .carry(carry), .zero(zero),
        .exec_ready(exec_ready), .resume(resume), .enableFetch(enableFetch),
        .enableCounter(enableCounter), .load(load), .valueLoad(valueLoad),
        .exec_valid(exec_valid), .exec_op(exec_op), .exec_operand(exec_operand),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            fr <= '0;
        end else begin
            if (load)               pc <= valueLoad;
            else if (enableCounter) pc <= pc + 12'd1;
            if (enableFetch)        fr <= programByte;
        end
    end

    assign programByte = rom[pc];
    assign instr       = fr[7:4];
    assign operand     = fr[3:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom(input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[0] = b0;
        rom[1] = b1;
    endtask

    // Reset, release, then run IDLE and FETCH so the first byte sits in DECODE
    task automatic start_to_decode();
        reset = 1'b0; exec_ready = 1'b0; resume = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        step();
    endtask

    function automatic logic [3:0] ctl();
        return {enableFetch, enableCounter, load, exec_valid};
    endfunction

    initial begin
        reset = 1'b0; carry = 1'b0; zero = 1'b0; exec_ready = 1'b0; resume = 1'b0;
        load_rom(8'h00, 8'h00);
        #1;
        chk("rst_ctl", ctl(), 4'b0000);
        chk("rst_vl", valueLoad, 12'h000);
        chk("rst_halted", halted, 1'b0);
        chk("rst_retired", retired, 0);

        // NOP stream
        @(posedge clk); #1;
        reset = 1'b1;
        chk("nop_idle", ctl(), 4'b0000);
        step();
        chk("nop_fetch", ctl(), 4'b1100);
        step();
        chk("nop_dec_pc", pc, 12'd1);
        chk("nop_dec_ctl", ctl(), 4'b0000);
        chk("nop_dec_ret", retired, 0);
        step();
        chk("nop_ret1", retired, 1);
        chk("nop_fetch2", ctl(), 4'b1100);
        step(); step();
        chk("nop_ret2", retired, 2);
        chk("nop_pc2", pc, 12'd2);

        // JMP 0x37A
        load_rom(8'h53, 8'h7A);
        rom[12'h37A] = 8'h0E;
        start_to_decode();
        chk("jmp_ctl", ctl(), 4'b0010);
        chk("jmp_vl", valueLoad, 12'h37A);
        step();
        chk("jmp_pc", pc, 12'h37A);
        chk("jmp_ret", retired, 1);
        step();
        chk("jmp_fetched", fr, 8'h0E);
        chk("jmp_pc_after", pc, 12'h37B);

        // JC not taken / taken
        load_rom(8'h12, 8'h34);
        carry = 1'b0;
        start_to_decode();
        chk("jc_nt_ctl", ctl(), 4'b0100);
        chk("jc_nt_vl", valueLoad, 12'h000);
        step();
        chk("jc_nt_pc", pc, 12'd2);
        carry = 1'b1;
        start_to_decode();
        chk("jc_t_ctl", ctl(), 4'b0010);
        chk("jc_t_vl", valueLoad, 12'h234);
        step();
        chk("jc_t_pc", pc, 12'h234);
        carry = 1'b0;

        // JNZ not taken / taken
        load_rom(8'h45, 8'h67);
        zero = 1'b1;
        start_to_decode();
        chk("jnz_nt_ctl", ctl(), 4'b0100);
        step();
        chk("jnz_nt_pc", pc, 12'd2);
        zero = 1'b0;
        start_to_decode();
        chk("jnz_t_ctl", ctl(), 4'b0010);
        chk("jnz_t_vl", valueLoad, 12'h567);
        step();
        chk("jnz_t_pc", pc, 12'h567);

        // EXEC with 5-cycle stall
        load_rom(8'h9C, 8'h00);
        start_to_decode();
        chk("ex_dec_ctl", ctl(), 4'b0000);
        step();
        for (int i = 0; i < 6; i++) begin
            chk("ex_stall_ctl", ctl(), 4'b0001);
            chk("ex_stall_op", {exec_op, exec_operand}, 8'h9C);
            chk("ex_stall_ret", retired, 0);
            if (i < 5) step();
        end
        exec_ready = 1'b1;
        step();
        exec_ready = 1'b0;
        chk("ex_ret", retired, 1);
        chk("ex_fetch_ctl", ctl(), 4'b1100);
        chk("ex_fetch_pc", pc, 12'd1);

        // HALT and resume
        load_rom(8'hF0, 8'h00);
        start_to_decode();
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("halt_ret", retired, 1);
        for (int i = 0; i < 10; i++) begin
            chk("halt_flag", halted, 1'b1);
            chk("halt_ctl", ctl(), 4'b0000);
            step();
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_halted", halted, 1'b0);
        chk("resume_ctl", ctl(), 4'b1100);
        chk("resume_pc", pc, 12'd1);
        chk("resume_ret", retired, 1);

        // Async reset mid-EXEC
        load_rom(8'h00, 8'h9C);
        start_to_decode();
        step(); step(); step();
        chk("ar_pre_ex", exec_valid, 1'b1);
        chk("ar_pre_ret", retired, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_ctl", ctl(), 4'b0000);
        chk("ar_op", {exec_op, exec_operand}, 8'h00);
        chk("ar_ret", retired, 0);
        exec_ready = 1'b1;
        step();
        chk("ar_hold_ret", retired, 0);
        reset = 1'b1;
        exec_ready = 1'b0;
        chk("ar_idle", ctl(), 4'b0000);
        step();
        chk("ar_fetch", ctl(), 4'b1100);

        // Retired counter wrap at 2^CNT_W
        load_rom(8'h00, 8'h00);
        start_to_decode();
        for (int i = 0; i < 15; i++) begin
            step(); step();
        end
        chk("wrap_15", retired, 15);
        step();
        chk("wrap_0", retired, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Control unit that consumes the 4-bit instr/operand pair held by the instruction fetch register.
- Drives the program-counter controls (enableCounter, load, valueLoad) and the fetch-register enable (enableFetch).
- Decodes each opcode: resolves conditional/unconditional two-byte jumps locally, and hands single-byte data/ALU ops to the datapath over a valid/ready handshake.
- Also handles HALT/resume and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps)
HALT_OP, 4'hF, opcode that halts the sequencer

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0); top level feeds its inverse to the active-high counter/fetch resets
instr  input  4  opcode from fetch register
operand  input  4  operand nibble from fetch register
programByte  input  8  current ROM byte at PC (combinational)
carry  input  1  datapath carry flag
zero  input  1  datapath zero flag
exec_ready  input  1  datapath accepts op
resume  input  1  leave HALT
enableFetch  output  1  fetch register capture enable
enableCounter  output  1  PC increment
load  output  1  PC load (never asserted with enableCounter)
valueLoad  output  12  PC load value
exec_valid  output  1  op offered to datapath
exec_op  output  4  opcode offered
exec_operand  output  4  operand offered
halted  output  1  sequencer in HALT
retired  output  CNT_W  instructions retired

Behaviour:
- Reset (reset=0, asynchronous): state=S_IDLE, retired=0. All control outputs are 0, valueLoad=0, halted=0.
- States: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT. Outputs are decoded combinationally from state, instr, flags and programByte.
- S_IDLE: all outputs 0; unconditionally -> S_FETCH. Guarantees a clean first edge after reset release.
- S_FETCH: enableFetch=1 and enableCounter=1. The fetch register captures the byte at PC and PC increments on the same edge; -> S_DECODE.
- S_DECODE: decode instr.
  - 0x0 NOP: retire; -> S_FETCH.
  - Jumps, two-byte: 0x1 JC (carry=1), 0x2 JNC (carry=0), 0x3 JZ (zero=1), 0x4 JNZ (zero=0), 0x5 JMP (always). Target = {operand, programByte}; programByte here is the byte at PC, i.e. the second instruction byte.
    - Taken: load=1, valueLoad={operand,programByte}.
    - Not taken: enableCounter=1, skipping the address byte.
    - Either way: retire; -> S_FETCH.
  - 0x6..0xE: -> S_EXEC.
  - HALT_OP: retire; -> S_HALT.
- Flags are sampled in S_DECODE only; later flag changes have no effect.
- S_EXEC: exec_valid=1; exec_op and exec_operand equal instr and operand, held stable.
  - Transfer on an edge with exec_valid=1 and exec_ready=1: retire; -> S_FETCH.
  - Otherwise stay in S_EXEC (unbounded stall allowed).
- S_HALT: halted=1; all PC/fetch controls 0. resume=1 at an edge -> S_FETCH; PC already points past HALT.
- Retire: retired increments by 1 on that edge and wraps at 2^CNT_W-1 -> 0.
- valueLoad is 0 whenever load=0.
- load and enableCounter are mutually exclusive in every state.
- Reset mid-instruction (any state) aborts immediately. No exec transfer or retire is counted for an aborted instruction.
- resume outside S_HALT is ignored. exec_ready outside S_EXEC is ignored.
- Illegal state encodings recover to S_IDLE.

Test Plan:
1. Reset release, ROM[0]=0x00 (NOP), ROM[1]=0x00 -> cycle1 idle, then enableFetch/enableCounter pulse every 2nd cycle; retired=1,2,... and PC=1,2.
2. ROM[0]=0x53, ROM[1]=0x7A (JMP 0x37A) -> in S_DECODE load=1, valueLoad=0x37A, enableCounter=0; next fetch reads address 0x37A; retired=1.
3. ROM[0]=0x12, ROM[1]=0x34 (JC 0x234): carry=0 -> enableCounter=1, next fetch at PC=2. Repeat with carry=1 -> load with valueLoad=0x234. Same pair of checks for JNZ with zero=1/0.
4. ROM[0]=0x9C, exec_ready held 0 for 5 cycles then 1 -> exec_valid=1, exec_op=0x9, exec_operand=0xC stable for 6 cycles; no PC activity; single retire; fetch resumes at PC=1.
5. ROM[0]=0xF0 -> halted=1, no enables for 10 cycles; resume pulse -> fetch at PC=1, halted=0; retired=1.
6. Assert reset=0 while in S_EXEC with exec_ready=0 -> all outputs 0 immediately (asynchronous), retired=0. After release, sequence restarts via S_IDLE.
